// File: rtl/mtx_ctrl_pkg.sv
// Shared definitions for the multitone TX burst sequencer and its generator.
package mtx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_GUARD = 2'd3
    } mtx_state_e;

    // Must match the NSIG/NSYMB used for the generator instance.
    localparam int unsigned MTX_NSIG  = 4096;
    localparam int unsigned MTX_NSYMB = 256;

endpackage

// File: rtl/mtx_guard_timer.sv
// Loadable down-counter with a zero flag; times the inter-burst guard gap.
module mtx_guard_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mtx_burst_ctrl.sv
// Burst sequencer for the multitone generator: drives gen_srst and the DDS
// phase-stream qualifiers, running bursts of NSYMB x NSIG samples with guards.
module mtx_burst_ctrl
    import mtx_ctrl_pkg::*;
#(
    parameter int unsigned NSIG_WIDTH   = 24,
    parameter int unsigned NSYMB_WIDTH  = 16,
    parameter int unsigned NBURST_WIDTH = 16,
    parameter int unsigned GUARD_WIDTH  = 16,
    parameter int unsigned NSIG         = MTX_NSIG,
    parameter int unsigned NSYMB        = MTX_NSYMB
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    stop,
    input  logic [NBURST_WIDTH-1:0] num_bursts,
    input  logic [GUARD_WIDTH-1:0]  guard_len,
    input  logic                    phase_tready,
    output logic                    gen_srst,
    output logic                    phase_tvalid,
    output logic                    phase_tlast,
    output logic                    burst_sync,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun,
    output logic [NBURST_WIDTH-1:0] burst_cnt,
    output logic [NSYMB_WIDTH-1:0]  symb_cnt
);

    localparam logic [NSIG_WIDTH-1:0]  SAMPLE_LAST = NSIG_WIDTH'(NSIG - 1);
    localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST   = NSYMB_WIDTH'(NSYMB - 1);

    mtx_state_e              state_q, state_d;
    logic [NSIG_WIDTH-1:0]   sample_q, sample_d;
    logic [NSYMB_WIDTH-1:0]  symb_q, symb_d;
    logic [NBURST_WIDTH-1:0] burst_q, burst_d;
    logic [NBURST_WIDTH-1:0] nburst_q, nburst_d;
    logic [GUARD_WIDTH-1:0]  guard_q, guard_d;
    logic                    pend_q, pend_d;
    logic                    underrun_q, underrun_d;

    logic srst_q, srst_d;
    logic tvalid_q, tvalid_d;
    logic tlast_q, tlast_d;
    logic sync_q, sync_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic                    tmr_load, tmr_dec, tmr_zero;
    logic [NBURST_WIDTH:0]   burst_inc;
    logic [NBURST_WIDTH-1:0] burst_sat;
    logic                    last_sample, last_symb;

    mtx_guard_timer #(
        .WIDTH(GUARD_WIDTH)
    ) u_guard_timer (
        .clk_i      (clk),
        .rst_ni     (resetn),
        .load_i     (tmr_load),
        .load_val_i (guard_q - GUARD_WIDTH'(1)),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    assign burst_inc   = {1'b0, burst_q} + (NBURST_WIDTH + 1)'(1);
    assign burst_sat   = (&burst_q) ? burst_q : burst_inc[NBURST_WIDTH-1:0];
    assign last_sample = (sample_q == SAMPLE_LAST);
    assign last_symb   = (symb_q == SYMB_LAST);

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        symb_d     = symb_q;
        burst_d    = burst_q;
        nburst_d   = nburst_q;
        guard_d    = guard_q;
        pend_d     = pend_q;
        underrun_d = underrun_q | (tvalid_q & ~phase_tready);
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d    = ST_PRIME;
                    nburst_d   = num_bursts;
                    guard_d    = guard_len;
                    burst_d    = '0;
                    underrun_d = 1'b0;
                    pend_d     = 1'b0;
                    sample_d   = '0;
                    symb_d     = '0;
                end
            end
            ST_PRIME: begin
                state_d = ST_RUN;
                if (stop) pend_d = 1'b1;
            end
            ST_RUN: begin
                if (stop) pend_d = 1'b1;
                if (last_sample) begin
                    sample_d = '0;
                    if (last_symb) begin
                        symb_d  = '0;
                        burst_d = burst_sat;
                    end else begin
                        symb_d = symb_q + NSYMB_WIDTH'(1);
                    end
                    // A stop (pending or coincident) wins over any burst-end routing.
                    if (stop || pend_q) begin
                        state_d = ST_IDLE;
                    end else if (last_symb) begin
                        if ((nburst_q != '0) && (burst_inc == {1'b0, nburst_q})) begin
                            state_d = ST_IDLE;
                        end else if (guard_q != '0) begin
                            state_d  = ST_GUARD;
                            tmr_load = 1'b1;
                        end
                    end
                end else begin
                    sample_d = sample_q + NSIG_WIDTH'(1);
                end
            end
            ST_GUARD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero) begin
                    state_d = ST_PRIME;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
            sample_d = '0;
            symb_d   = '0;
            pend_d   = 1'b0;
        end

        // Outputs are registered from next-state values so they align with state_q.
        srst_d   = !((state_d == ST_PRIME) || (state_d == ST_RUN));
        tvalid_d = (state_d == ST_RUN);
        tlast_d  = (state_d == ST_RUN) && (sample_d == SAMPLE_LAST);
        sync_d   = (state_d == ST_RUN) && (sample_d == '0) && (symb_d == '0);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            sample_q   <= '0;
            symb_q     <= '0;
            burst_q    <= '0;
            nburst_q   <= '0;
            guard_q    <= '0;
            pend_q     <= 1'b0;
            underrun_q <= 1'b0;
            srst_q     <= 1'b1;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            sync_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            symb_q     <= symb_d;
            burst_q    <= burst_d;
            nburst_q   <= nburst_d;
            guard_q    <= guard_d;
            pend_q     <= pend_d;
            underrun_q <= underrun_d;
            srst_q     <= srst_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            sync_q     <= sync_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign gen_srst     = srst_q;
    assign phase_tvalid = tvalid_q;
    assign phase_tlast  = tlast_q;
    assign burst_sync   = sync_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign underrun     = underrun_q;
    assign burst_cnt    = burst_q;
    assign symb_cnt     = symb_q;

endmodule

// File: tb/tb_mtx_burst_ctrl.sv
// Bench for mtx_burst_ctrl: builds the expected per-cycle output schedule of each
// run from the burst/guard/stop rules and checks the DUT against it.
module tb_mtx_burst_ctrl;

    localparam int NSIG  = 4;
    localparam int NSYMB = 2;
    localparam int BLEN  = NSIG * NSYMB;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] num_bursts = '0;
    logic [15:0] guard_len = '0;
    logic        phase_tready = 1'b1;
    logic        gen_srst, phase_tvalid, phase_tlast, burst_sync, busy, done, underrun;
    logic [15:0] burst_cnt;
    logic [15:0] symb_cnt;

    int total = 0;
    int bad = 0;

    typedef struct {
        bit srst;
        bit tvalid;
        bit tlast;
        bit sync;
        bit busy;
        bit done;
        int symb;
        int bcnt;
    } cyc_t;

    cyc_t sched[$];

    mtx_burst_ctrl #(
        .NSIG  (NSIG),
        .NSYMB (NSYMB)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .stop         (stop),
        .num_bursts   (num_bursts),
        .guard_len    (guard_len),
        .phase_tready (phase_tready),
        .gen_srst     (gen_srst),
        .phase_tvalid (phase_tvalid),
        .phase_tlast  (phase_tlast),
        .burst_sync   (burst_sync),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun),
        .burst_cnt    (burst_cnt),
        .symb_cnt     (symb_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input int i, input cyc_t e, input bit exp_un);
        chk($sformatf("%s[%0d].gen_srst", tag, i), 32'(gen_srst), 32'(e.srst));
        chk($sformatf("%s[%0d].tvalid", tag, i), 32'(phase_tvalid), 32'(e.tvalid));
        chk($sformatf("%s[%0d].tlast", tag, i), 32'(phase_tlast), 32'(e.tlast));
        chk($sformatf("%s[%0d].burst_sync", tag, i), 32'(burst_sync), 32'(e.sync));
        chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(e.busy));
        chk($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(e.done));
        chk($sformatf("%s[%0d].underrun", tag, i), 32'(underrun), 32'(exp_un));
        chk($sformatf("%s[%0d].symb_cnt", tag, i), 32'(symb_cnt), 32'(e.symb));
        chk($sformatf("%s[%0d].burst_cnt", tag, i), 32'(burst_cnt), 32'(e.bcnt));
    endtask

    function automatic cyc_t mk(bit srst, bit tv, bit tl, bit sy, bit bz, bit dn, int symb, int bcnt);
        cyc_t c;
        c.srst = srst; c.tvalid = tv; c.tlast = tl; c.sync = sy;
        c.busy = bz; c.done = dn; c.symb = symb; c.bcnt = bcnt;
        return c;
    endfunction

    // Untruncated schedule length for nb bursts (nb==0 expands to maxb bursts).
    function automatic int sched_len(int nb, int g, int maxb);
        int tot;
        tot = (nb == 0) ? maxb : nb;
        return tot * BLEN + ((g != 0) ? tot + (tot - 1) * g : 1);
    endfunction

    // Expected cycles from PRIME up to and including the IDLE cycle carrying done.
    function automatic void build(int nb, int g, int stop_cyc, int maxb);
        int tot, cut, fb;
        bit is_guard;
        tot = (nb == 0) ? maxb : nb;
        sched.delete();
        for (int b = 0; b < tot; b++) begin
            if (b == 0 || g != 0) sched.push_back(mk(0, 0, 0, 0, 1, 0, 0, b));
            for (int k = 0; k < BLEN; k++)
                sched.push_back(mk(0, 1, (k % NSIG) == NSIG - 1, k == 0, 1, 0, k / NSIG, b));
            if (b != tot - 1 && g != 0)
                for (int j = 0; j < g; j++) sched.push_back(mk(1, 0, 0, 0, 1, 0, 0, b + 1));
        end
        fb = tot;
        if (stop_cyc >= 0) begin
            is_guard = sched[stop_cyc].srst;
            cut = stop_cyc;
            if (!is_guard) while (!sched[cut].tlast) cut++;
            fb = sched[cut].bcnt + ((!is_guard && sched[cut].symb == NSYMB - 1) ? 1 : 0);
            while (sched.size() > cut + 1) void'(sched.pop_back());
        end
        sched.push_back(mk(1, 0, 0, 0, 0, 1, 0, fb));
    endfunction

    // Start one run, walk the schedule cycle by cycle, then check the quiet IDLE after done.
    task automatic run(input string tag, input int nb, input int g, input int stop_cyc,
                       input int maxb, input int low_idx, input int low_pct);
        bit   exp_un;
        bit   low;
        cyc_t idle;
        build(nb, g, stop_cyc, maxb);
        num_bursts = 16'(nb);
        guard_len  = 16'(g);
        start = 1'b1;
        step();
        start = 1'b0;
        exp_un = 1'b0;
        for (int i = 0; i < sched.size(); i++) begin
            low = (i == low_idx) || ($urandom_range(99) < low_pct);
            phase_tready = ~low;
            stop = (i == stop_cyc);
            chk_cycle(tag, i, sched[i], exp_un);
            exp_un = exp_un | (sched[i].tvalid & low);
            step();
        end
        stop = 1'b0;
        phase_tready = 1'b1;
        idle = sched[sched.size() - 1];
        idle.done = 1'b0;
        chk_cycle(tag, sched.size(), idle, exp_un);
    endtask

    initial begin
        int nb, g, sc, maxb;

        resetn = 1'b0;
        step();
        step();
        chk_cycle("reset", 0, mk(1, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        resetn = 1'b1;
        step();

        run("t1_single", 1, 3, -1, 1, -1, 0);
        run("t2_guard3", 2, 3, -1, 2, -1, 0);
        run("t3_seamless", 2, 0, -1, 2, -1, 0);
        // stop on 2nd sample of symbol 1: PRIME at 0, sample k at 1+k
        run("t4_stop", 0, $urandom_range(1, 4), 1 + NSIG + 1, 3, -1, 0);
        run("t5_underrun", 1, 2, -1, 1, 3, 0);
        run("t5_clear", 1, 1, -1, 1, -1, 0);

        for (int r = 0; r < 8; r++) begin
            nb   = $urandom_range(0, 3);
            g    = $urandom_range(0, 4);
            maxb = 3;
            sc   = $urandom_range(0, sched_len(nb, g, maxb) - 1);
            if (nb != 0 && $urandom_range(1) == 0) sc = -1;
            run($sformatf("rand%0d", r), nb, g, sc, maxb, -1, 15);
        end

        // reset mid-RUN aborts without done
        num_bursts = 16'd0;
        guard_len  = 16'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("t6_running.tvalid", 32'(phase_tvalid), 32'd1);
        resetn = 1'b0;
        step();
        chk_cycle("t6_reset", 0, mk(1, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        resetn = 1'b1;
        step();
        chk_cycle("t6_after", 1, mk(1, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk_cycle("t6_startstop", 0, mk(1, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        step();
        chk_cycle("t6_startstop", 1, mk(1, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
